// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - producer and register-file write bundle for rf_write_arbiter
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [DATA_WIDTH-1:0] a_data;

  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_address;
  logic [DATA_WIDTH-1:0] b_data;

  logic                  rf_write_enable;
  logic [ADDR_WIDTH-1:0] rf_write_address;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic [CW-1:0]         b_count;
  logic                  idle;

  modport slave (
    input  a_valid, a_address, a_data, b_valid, b_address, b_data,
    output a_ready, b_ready, rf_write_enable, rf_write_address, rf_write_data, b_count, idle
  );

  modport master (
    output a_valid, a_address, a_data, b_valid, b_address, b_data,
    input  a_ready, b_ready, rf_write_enable, rf_write_address, rf_write_data, b_count, idle
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter, A priority, buffered B with anti-starvation
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input logic              clk,
  input logic              reset,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [WW-1:0]         wait_cnt;

  logic                  empty;
  logic                  full;
  logic                  force_b;
  logic                  sel_a;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign force_b = !empty && (wait_cnt == WW'(MAX_WAIT));
  assign sel_a   = bus.a_valid && !force_b;
  assign pop     = !sel_a && !empty;
  // Fullness is judged before any same-cycle pop, so a full queue never accepts.
  assign push    = bus.b_valid && !full;

  assign sel_addr = sel_a ? bus.a_address : mem[rd_ptr][EW-1:DATA_WIDTH];
  assign sel_data = sel_a ? bus.a_data    : mem[rd_ptr][DATA_WIDTH-1:0];

  assign bus.a_ready = !force_b;
  assign bus.b_ready = !full;
  assign bus.b_count = count;
  assign bus.idle    = empty && !bus.rf_write_enable;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.b_address, bus.b_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Counts edges the head was bypassed; force_b pops it at MAX_WAIT, so it never overflows.
      if (empty || pop) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rf_write_enable  <= 1'b0;
      bus.rf_write_address <= '0;
      bus.rf_write_data    <= '0;
    end else if (sel_a || pop) begin
      bus.rf_write_enable  <= (sel_addr != '0);
      bus.rf_write_address <= sel_addr;
      bus.rf_write_data    <= sel_data;
    end else begin
      bus.rf_write_enable  <= 1'b0;
    end
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two producers. Port A is the core writeback path and has priority. Port B is a slow-unit path, such as multiply/divide or a multi-cycle load, and is buffered in a small FIFO. An anti-starvation counter guarantees B forward progress. The block drives the register file's write_enable, write_address and write_data through registered outputs.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width
FIFO_DEPTH, 4, B-side queue entries; power of 2, at least 2
MAX_WAIT, 3, max cycles a non-empty B head may be bypassed by A; at least 1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
a_valid  in  1  A write request
a_ready  out  1  A request accepted this cycle when a_valid is also high
a_address  in  ADDR_WIDTH  A destination register
a_data  in  DATA_WIDTH  A write value
b_valid  in  1  B write request
b_ready  out  1  B FIFO not full
b_address  in  ADDR_WIDTH  B destination register
b_data  in  DATA_WIDTH  B write value
rf_write_enable  out  1  register file write strobe (registered)
rf_write_address  out  ADDR_WIDTH  register file write index (registered)
rf_write_data  out  DATA_WIDTH  register file write data (registered)
b_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
idle  out  1  FIFO empty and rf_write_enable low

Behaviour:
- Reset (async, any time, including mid-drain):
  - FIFO pointers, b_count, wait counter and all rf_write_* outputs go to 0.
  - Queued B entries are discarded.
  - Outputs: b_ready=1, a_ready=1, idle=1.
- B enqueue: on a rising edge with b_valid & b_ready, push {b_address, b_data}.
  - b_ready = (b_count != FIFO_DEPTH).
  - No enqueue while full, even if a pop happens in the same cycle.
  - No bypass: an entry pushed at edge N is first eligible for grant during cycle N+1.
- Wait counter:
  - Increments on each edge where the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
  - force_b = (wait_cnt == MAX_WAIT) & FIFO non-empty.
- a_ready = !force_b (combinational). A is otherwise never stalled.
- Grant per cycle (exactly one or none):
  - If a_valid & a_ready: select A.
  - Else if FIFO non-empty: select the FIFO head and pop it at the edge.
  - Else: nothing.
- Output register, one-cycle latency. At each edge, load the selected request:
  - rf_write_address / rf_write_data = selected address and data.
  - rf_write_enable = selected & (address != 0).
  - With no selection, rf_write_enable=0 and address/data hold their previous values.
- Register 0 writes are still accepted or popped normally but never strobe rf_write_enable.
- The register file commits a write at the edge following the one that loaded the outputs. Total latency from request acceptance to register file update is 2 edges.
- Simultaneous B push and pop: b_count stays unchanged; FIFO order is preserved.
- Pointers wrap modulo FIFO_DEPTH; b_count alone distinguishes full from empty.
- Worst-case B head latency under continuous A traffic: MAX_WAIT+1 cycles from eligibility to pop.

Test Plan:
1. Reset: assert reset mid-cycle with 3 B entries queued -> b_count=0, rf_write_enable=0, b_ready=1, idle=1 immediately, without waiting for a clock edge.
2. A only: a_valid=1, a_address=5, a_data=0xDEADBEEF at edge N -> a_ready=1; during cycle N+1, rf_write_enable=1, address=5, data=0xDEADBEEF; idle=0.
3. B burst with A idle: push (3,0x11), (4,0x22), (6,0x33) on consecutive edges -> rf_write_* reproduces them in order, one per cycle, with the first output one cycle after the first entry becomes eligible; b_count peaks at 1 and returns to 0.
4. Starvation: A held valid continuously, one B push (7,0xCAFE), MAX_WAIT=3 -> A granted 3 cycles, then a_ready=0 for exactly 1 cycle; the B write to register 7 appears on the next cycle; a_ready returns to 1.
5. Full FIFO: A saturating, push 5 B entries back-to-back -> b_ready=0 after the 4th push, b_count=4, 5th entry held off; b_ready=1 again the cycle after the first forced pop.
6. Register 0: A write to address 0 with data 0xFFFFFFFF, then B write to address 0 -> both consumed (a_ready=1, b_count decrements); rf_write_enable stays 0 throughout.
